// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 core: opcode encodings and
// the fetch/decode/execute stage enumeration used by the sequencer.
package cpu8_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_LW   = 3'b000;
    localparam logic [OPC_W-1:0] OP_SW   = 3'b001;
    localparam logic [OPC_W-1:0] OP_JMP  = 3'b010;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b011;
    localparam logic [OPC_W-1:0] OP_ADDI = 3'b100;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b101;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } stage_e;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // 110 and 111 are unassigned encodings
    function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: fetches one 8-bit word, then walks it
// through decode/execute/memory/writeback, tracking pc and retired count.
module fetch_sequencer
    import cpu8_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       halt,
    input  logic       imem_ready,
    input  logic [7:0] imem_rdata,
    input  logic       jump,
    output logic       imem_req,
    output logic [7:0] pc,
    output logic [7:0] instr,
    output logic [2:0] opcode,
    output logic       id_stage,
    output logic       ex_stage,
    output logic       mem_stage,
    output logic       wb_stage,
    output logic       illegal,
    output logic [7:0] retired
);

    stage_e     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_retired;
    logic       r_illegal;
    logic       r_id;
    logic       r_ex;
    logic       r_mem;
    logic       r_wb;
    logic [2:0] w_op;
    logic       w_fetch_go;

    assign w_op       = r_instr[7:5];
    assign w_fetch_go = (r_state == ST_FETCH) && !halt && imem_ready;

    // Request is the only output that must react to halt in the same cycle
    assign imem_req  = (r_state == ST_FETCH) && !halt && !reset;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign opcode    = w_op;
    assign retired   = r_retired;
    assign illegal   = r_illegal;
    assign id_stage  = r_id;
    assign ex_stage  = r_ex;
    assign mem_stage = r_mem;
    assign wb_stage  = r_wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= 8'h00;
            r_retired <= 8'h00;
            r_illegal <= 1'b0;
            r_id      <= 1'b0;
            r_ex      <= 1'b0;
            r_mem     <= 1'b0;
            r_wb      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (w_fetch_go) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_pc + 8'd1;
                        r_id    <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_id <= 1'b0;
                    if (is_illegal_op(w_op)) begin
                        r_illegal <= 1'b1;
                    end
                    if (jump) begin
                        r_pc      <= {3'b000, r_instr[4:0]};
                        r_retired <= r_retired + 8'd1;
                        r_state   <= ST_FETCH;
                    end else begin
                        r_ex    <= 1'b1;
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_ex <= 1'b0;
                    if (is_mem_op(w_op)) begin
                        r_mem   <= 1'b1;
                        r_state <= ST_MEMORY;
                    end else begin
                        r_wb    <= 1'b1;
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    r_mem   <= 1'b0;
                    r_wb    <= 1'b1;
                    r_state <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    r_wb      <= 1'b0;
                    r_retired <= r_retired + 8'd1;
                    r_state   <= ST_FETCH;
                end
                default: begin
                    r_id    <= 1'b0;
                    r_ex    <= 1'b0;
                    r_mem   <= 1'b0;
                    r_wb    <= 1'b0;
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed table, corner sequences and
// random stimulus against a stage-schedule reference model.
module tb_fetch_sequencer;

    localparam logic [7:0] RPC = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       halt = 1'b0;
    logic       imem_ready = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       jump = 1'b0;
    logic       imem_req;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [2:0] opcode;
    logic       id_stage;
    logic       ex_stage;
    logic       mem_stage;
    logic       wb_stage;
    logic       illegal;
    logic [7:0] retired;

    fetch_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .jump(jump),
        .imem_req(imem_req), .pc(pc), .instr(instr), .opcode(opcode),
        .id_stage(id_stage), .ex_stage(ex_stage), .mem_stage(mem_stage),
        .wb_stage(wb_stage), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining stages of the in-flight instruction
    localparam int S_ID = 0, S_EX = 1, S_MEM = 2, S_WB = 3;
    int         sched[$];
    logic [7:0] m_pc, m_instr, m_ret;
    logic       m_ill;
    bit         m_valid = 0;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic [3:0] e_st;
        logic       e_req;
        e_st = 4'b0000;
        e_req = 1'b0;
        if (sched.size() == 0) e_req = !reset && !halt;
        else e_st[3 - sched[0]] = 1'b1;
        chk("imem_req", {7'd0, imem_req}, {7'd0, e_req});
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
        chk("opcode", {5'd0, opcode}, {5'd0, m_instr[7:5]});
        chk("strobes", {4'd0, id_stage, ex_stage, mem_stage, wb_stage},
            {4'd0, e_st});
        chk("retired", retired, m_ret);
        chk("illegal", {7'd0, illegal}, {7'd0, m_ill});
    endtask

    task automatic model_upd();
        int s;
        if (reset) begin
            sched.delete();
            m_pc = RPC; m_instr = 8'h00; m_ret = 8'h00; m_ill = 1'b0;
            m_valid = 1;
        end else if (sched.size() == 0) begin
            if (!halt && imem_ready) begin
                m_instr = imem_rdata;
                m_pc = m_pc + 8'd1;
                sched.push_back(S_ID);
            end
        end else begin
            s = sched.pop_front();
            if (s == S_ID) begin
                if (m_instr[7:5] >= 3'd6) m_ill = 1'b1;
                if (jump) begin
                    m_pc = {3'b000, m_instr[4:0]};
                    m_ret = m_ret + 8'd1;
                end else begin
                    sched.push_back(S_EX);
                    if (m_instr[7:5] <= 3'd1) sched.push_back(S_MEM);
                    sched.push_back(S_WB);
                end
            end else if (s == S_WB) begin
                m_ret = m_ret + 8'd1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic rd,
                         input logic [7:0] d, input logic j);
        @(negedge clk);
        reset = r; halt = h; imem_ready = rd; imem_rdata = d; jump = j;
        #1;
        if (m_valid) model_cmp();
    endtask

    task automatic step(input logic r, input logic h, input logic rd,
                        input logic [7:0] d, input logic j);
        drive(r, h, rd, d, j);
        model_upd();
    endtask

    typedef struct {
        logic       rdy;
        logic [7:0] rdata;
        logic       jmp;
        logic       req;
        logic [7:0] pc;
        logic [3:0] st;
        logic [7:0] ret;
    } vec_t;

    vec_t vt[12];

    initial begin
        int budget;
        logic [7:0] hold_pc;

        // add, jmp 5A -> 1A, lw at 1A, then a stalled fetch
        vt[0]  = '{1'b1, 8'h60, 1'b0, 1'b1, 8'h00, 4'b0000, 8'd0};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'b1000, 8'd0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'b0100, 8'd0};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'b0001, 8'd0};
        vt[4]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h01, 4'b0000, 8'd1};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 4'b1000, 8'd1};
        vt[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h1A, 4'b0000, 8'd2};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1B, 4'b1000, 8'd2};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1B, 4'b0100, 8'd2};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1B, 4'b0010, 8'd2};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1B, 4'b0001, 8'd2};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1B, 4'b0000, 8'd3};

        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h33, 0);
        drive(0, 0, 0, 8'h00, 0);
        chk("rst_pc", pc, RPC);
        chk("rst_instr", instr, 8'h00);
        chk("rst_ret", retired, 8'h00);
        chk("rst_strb", {4'd0, id_stage, ex_stage, mem_stage, wb_stage}, 8'h00);
        model_upd();

        foreach (vt[i]) begin
            drive(0, 0, vt[i].rdy, vt[i].rdata, vt[i].jmp);
            chk($sformatf("tbl%0d_req", i), {7'd0, imem_req}, {7'd0, vt[i].req});
            chk($sformatf("tbl%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("tbl%0d_st", i),
                {4'd0, id_stage, ex_stage, mem_stage, wb_stage}, {4'd0, vt[i].st});
            chk($sformatf("tbl%0d_ret", i), retired, vt[i].ret);
            model_upd();
        end

        // Halt raised during EXECUTE of sub: WB completes, then no requests
        step(0, 0, 1, 8'hA0, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'h00, 0);
        drive(0, 1, 1, 8'h00, 0);
        chk("halt_wb", {7'd0, wb_stage}, 8'd1);
        model_upd();
        hold_pc = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 8'hC3, 0);
            chk("halt_req", {7'd0, imem_req}, 8'd0);
            chk("halt_pc", pc, hold_pc);
            model_upd();
        end

        // Illegal opcode 111 is sticky across later instructions
        step(0, 0, 1, 8'hE0, 0);
        step(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h61, 0);
        drive(0, 0, 0, 8'h00, 0);
        chk("ill_sticky", {7'd0, illegal}, 8'd1);
        model_upd();

        // Reset during MEMORY of lw discards it
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h05, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        chk("mem_before_rst", {7'd0, mem_stage}, 8'd1);
        model_upd();
        drive(0, 0, 0, 8'h00, 0);
        chk("rstm_pc", pc, RPC);
        chk("rstm_ret", retired, 8'h00);
        chk("rstm_strb", {4'd0, id_stage, ex_stage, mem_stage, wb_stage}, 8'h00);
        chk("rstm_ill", {7'd0, illegal}, 8'd0);
        model_upd();

        // Walk pc to FF, then check the wrap and a stalled fetch
        budget = 3000;
        while ((m_pc != 8'hFF || sched.size() != 0) && budget > 0) begin
            step(0, 0, 1, 8'h60, 0);
            budget--;
        end
        chk("wrap_budget", {7'd0, (budget > 0)}, 8'd1);
        step(0, 0, 1, 8'h60, 0);
        drive(0, 0, 0, 8'h00, 0);
        chk("wrap_pc", pc, 8'h00);
        model_upd();
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00, 0);
            chk("stall_req", {7'd0, imem_req}, 8'd1);
            chk("stall_pc", pc, 8'h00);
            model_upd();
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), 8'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
